// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary conversion and width helpers shared by both FIFO pointer blocks.
package fifo_pkg;
    localparam int MAXW = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits of a narrower pointer are zero, so one 32-bit prefix XOR serves every width.
    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/fifo_gray_sync.sv
// fifo_gray_sync: multi-flop synchroniser for a Gray pointer crossing clock domains.
module fifo_gray_sync #(
    parameter int W = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl: write-domain pointer, full/almost-full flags, fill level and overflow pulse.
module fifo_wptr_ctrl import fifo_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int AFULL_TH = 14,
    parameter int SYNC_STAGES = 2,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic          W_CLK,
    input  logic          W_RST,
    input  logic          W_INC,
    input  logic [AW:0]   gray_Rptr,
    output logic          W_EN,
    output logic [AW-1:0] Waddr,
    output logic [AW:0]   gray_Wptr,
    output logic          WFULL,
    output logic          WAFULL,
    output logic [AW:0]   WLEVEL,
    output logic          W_OVF
);
    localparam logic [AW:0] TH = AFULL_TH[AW:0];

    logic [AW:0] wptr, wnext, gnext, rg_s, rbin, diff;
    logic full_next;

    fifo_gray_sync #(.W(AW + 1), .STAGES(SYNC_STAGES)) u_rsync (
        .clk(W_CLK),
        .rst_n(W_RST),
        .d(gray_Rptr),
        .q(rg_s)
    );

    assign W_EN = W_INC & ~WFULL;
    assign Waddr = wptr[AW-1:0];
    assign wnext = wptr + (AW + 1)'(W_EN);
    assign gnext = (AW + 1)'(bin2gray(32'(wnext)));
    assign rbin = (AW + 1)'(gray2bin(32'(rg_s)));
    assign diff = wnext - rbin;
    // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next = gnext == {~rg_s[AW:AW-1], rg_s[AW-2:0]};

    always_ff @(posedge W_CLK) begin
        if (!W_RST) begin
            wptr      <= '0;
            gray_Wptr <= '0;
            WFULL     <= 1'b0;
            WAFULL    <= 1'b0;
            WLEVEL    <= '0;
            W_OVF     <= 1'b0;
        end else begin
            wptr      <= wnext;
            gray_Wptr <= gnext;
            WFULL     <= full_next;
            WAFULL    <= diff >= TH;
            WLEVEL    <= diff;
            W_OVF     <= W_INC & WFULL;
        end
    end
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb_fifo_wptr_ctrl: directed checks of the write-side FIFO controller at DEPTH=16.
module tb_fifo_wptr_ctrl;
    logic       W_CLK = 0, W_RST = 0, W_INC = 0;
    logic [4:0] gray_Rptr = '0;
    logic       W_EN, WFULL, WAFULL, W_OVF;
    logic [3:0] Waddr;
    logic [4:0] gray_Wptr, WLEVEL;
    int checks = 0, errors = 0;
    int tb_w;
    logic saw_wrap;

    fifo_wptr_ctrl #(.DEPTH(16), .AFULL_TH(14), .SYNC_STAGES(2)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .W_INC(W_INC), .gray_Rptr(gray_Rptr),
        .W_EN(W_EN), .Waddr(Waddr), .gray_Wptr(gray_Wptr), .WFULL(WFULL),
        .WAFULL(WAFULL), .WLEVEL(WLEVEL), .W_OVF(W_OVF)
    );

    always #5 W_CLK = ~W_CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge W_CLK);
        #1;
    endtask

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    initial begin
        W_INC = 1;
        tick();
        tick();
        chk("rst_waddr", Waddr, 0);
        chk("rst_gray", gray_Wptr, 0);
        chk("rst_full", WFULL, 0);
        chk("rst_afull", WAFULL, 0);
        chk("rst_level", WLEVEL, 0);
        chk("rst_ovf", W_OVF, 0);
        chk("rst_wen", W_EN, 1);

        W_RST = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("fill_level", WLEVEL, i);
            if (i == 13) chk("afull_13", WAFULL, 0);
            if (i == 14) chk("afull_14", WAFULL, 1);
            if (i == 15) chk("full_15", WFULL, 0);
        end
        chk("full_16", WFULL, 1);
        chk("gray_16", gray_Wptr, 5'b11000);

        for (int i = 0; i < 3; i++) begin
            chk("ovf_wen", W_EN, 0);
            tick();
            chk("ovf_pulse", W_OVF, 1);
            chk("ovf_waddr", Waddr, 0);
            chk("ovf_level", WLEVEL, 16);
        end
        W_INC = 0;
        tick();
        chk("ovf_clear", W_OVF, 0);

        gray_Rptr = 5'b00001;
        tick();
        chk("rel_e1", WFULL, 1);
        tick();
        chk("rel_e2", WFULL, 1);
        tick();
        chk("rel_full", WFULL, 0);
        chk("rel_level", WLEVEL, 15);
        chk("rel_afull", WAFULL, 1);

        tb_w = 16;
        gray_Rptr = g(tb_w);
        repeat (3) tick();
        chk("drain_level", WLEVEL, 0);
        chk("drain_afull", WAFULL, 0);
        saw_wrap = 0;
        W_INC = 1;
        for (int i = 0; i < 40; i++) begin
            gray_Rptr = g(tb_w);
            tick();
            tb_w = (tb_w + 1) % 32;
            if (tb_w == 0) saw_wrap = 1;
            chk("wrap_gray", gray_Wptr, g(tb_w));
            chk("wrap_waddr", Waddr, tb_w % 16);
            chk("wrap_full", WFULL, 0);
            chk("wrap_lvl_le3", int'(WLEVEL <= 3), 1);
        end
        chk("wrap_seen", saw_wrap, 1);

        W_INC = 0;
        gray_Rptr = g(tb_w);
        repeat (3) tick();
        chk("pre9_level", WLEVEL, 0);
        W_INC = 1;
        repeat (9) tick();
        W_INC = 0;
        tick();
        chk("lvl9", WLEVEL, 9);
        W_RST = 0;
        gray_Rptr = '0;
        tick();
        W_RST = 1;
        chk("mrst_waddr", Waddr, 0);
        chk("mrst_gray", gray_Wptr, 0);
        chk("mrst_level", WLEVEL, 0);
        chk("mrst_full", WFULL, 0);
        chk("mrst_afull", WAFULL, 0);
        chk("mrst_ovf", W_OVF, 0);
        W_INC = 1;
        #1;
        chk("post_wen", W_EN, 1);
        chk("post_waddr0", Waddr, 0);
        tick();
        W_INC = 0;
        chk("post_waddr1", Waddr, 1);
        chk("post_gray", gray_Wptr, 1);
        chk("post_level", WLEVEL, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
